branch_resolve_unit: RTL

- Consumer end of the branch-prediction loop.
- Records each fetched branch's low PC bits and predicted direction in an in-order queue.
- When the branch resolves in execute, compares the prediction with the actual outcome.
- Drives the predictor's update port (write address, taken, jumped), raises a mispredict flush, clears wrong-path entries and keeps saturating statistics counters.

---
 rtl/bp_defs.sv | 18 +
 rtl/bp_fifo.sv | 68 ++++++
 rtl/branch_resolve_unit.sv | 105 ++++++++++
 3 files changed

// File: rtl/bp_defs.sv
// bp_defs: definitions shared by the branch-prediction blocks (predictor
// table, branch resolve unit, fetch-redirect logic).
//   LOWER_DEF  default number of low PC bits used as the predictor index
//   CNT_W_DEF  default width of the statistics counters
//   Entry layout: pc_lo in bits [LOWER:1], predicted direction in bit [0].
package bp_defs;

  localparam int LOWER_DEF = 5;
  localparam int CNT_W_DEF = 16;

  localparam int PRED_BIT = 0;
  localparam int PC_LSB   = 1;

  function automatic int entry_width(input int lower);
    return lower + 1;
  endfunction

endpackage

// File: rtl/bp_fifo.sv
// bp_fifo: parameterised circular queue with push, pop and synchronous clear.
//   clk, arst_n      clock, asynchronous active-low reset
//   push, push_data  write request and data (ignored while full or clearing)
//   pop              read request (ignored while empty or clearing)
//   clear            empties the queue at the end of the cycle
//   head             oldest entry, read combinationally
//   count/full/empty occupancy status
module bp_fifo #(
  parameter int WIDTH = 6,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     arst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  input  logic                     clear,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full & ~clear;
  assign do_pop  = pop & ~empty & ~clear;
  assign head    = mem[rd_ptr];

  // DEPTH is a power of two, so the pointers wrap by plain overflow.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage is reset so head never carries undefined data.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit: consumer end of the branch-prediction loop.
// Queues each fetched branch's {pc_lo, pred}, compares the prediction with
// the outcome when the oldest branch resolves, and drives the predictor
// update port one cycle later.
//   clk, arst_n                        clock, asynchronous active-low reset
//   fetch_valid/pc_lo/pred, fetch_ready push side (fetched branches)
//   resolve_valid/taken/jump           pop side (execute-stage outcome)
//   upd_en/addr/taken/jumped           registered predictor update
//   mispredict                         registered one-cycle flush pulse
//   branch_cnt, mispred_cnt            saturating statistics
//   underflow                          sticky: pop seen on an empty queue
module branch_resolve_unit
  import bp_defs::*;
#(
  parameter int LOWER = LOWER_DEF,
  parameter int DEPTH = 4,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             arst_n,
  input  logic             fetch_valid,
  input  logic [LOWER-1:0] fetch_pc_lo,
  input  logic             fetch_pred,
  output logic             fetch_ready,
  input  logic             resolve_valid,
  input  logic             resolve_taken,
  input  logic             resolve_jump,
  output logic             upd_en,
  output logic [LOWER-1:0] upd_addr,
  output logic             upd_taken,
  output logic             upd_jumped,
  output logic             mispredict,
  output logic [CNT_W-1:0] branch_cnt,
  output logic [CNT_W-1:0] mispred_cnt,
  output logic             underflow
);

  localparam int ENTRY_W = entry_width(LOWER);

  logic [ENTRY_W-1:0]        head;
  logic [$clog2(DEPTH):0]    q_count;
  logic                      q_full;
  logic                      q_empty;
  logic                      pop_ok;
  logic                      push_ok;
  logic                      actual;
  logic                      mis_now;

  assign fetch_ready = ~q_full;
  assign pop_ok      = resolve_valid & (q_count != '0);
  assign actual      = resolve_taken | resolve_jump;
  assign mis_now     = pop_ok & (head[PRED_BIT] != actual);
  // Fetches in the detect cycle and the following pulse cycle are wrong-path.
  assign push_ok     = fetch_valid & fetch_ready & ~mis_now & ~mispredict;

  bp_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .arst_n    (arst_n),
    .push      (push_ok),
    .push_data ({fetch_pc_lo, fetch_pred}),
    .pop       (pop_ok),
    .clear     (mis_now),
    .head      (head),
    .count     (q_count),
    .full      (q_full),
    .empty     (q_empty)
  );

  // Update port is fully registered, breaking any path from resolve_* out.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      upd_en     <= 1'b0;
      upd_addr   <= '0;
      upd_taken  <= 1'b0;
      upd_jumped <= 1'b0;
      mispredict <= 1'b0;
    end else begin
      upd_en     <= pop_ok;
      upd_addr   <= head[LOWER:PC_LSB];
      upd_taken  <= resolve_taken;
      upd_jumped <= resolve_jump;
      mispredict <= mis_now;
    end
  end

  // Statistics saturate at all-ones instead of wrapping.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      branch_cnt  <= '0;
      mispred_cnt <= '0;
      underflow   <= 1'b0;
    end else begin
      if (pop_ok && (branch_cnt != {CNT_W{1'b1}}))
        branch_cnt <= branch_cnt + CNT_W'(1);
      if (mis_now && (mispred_cnt != {CNT_W{1'b1}}))
        mispred_cnt <= mispred_cnt + CNT_W'(1);
      if (resolve_valid && q_empty)
        underflow <= 1'b1;
    end
  end

endmodule
